// File: rtl/onehot_codec_pkg.sv
// Shared constants and helper functions for the one-hot codec.
package onehot_codec_pkg;

    // Conversion direction, sampled with each input word
    localparam logic MODE_B2OH = 1'b0;
    localparam logic MODE_OH2B = 1'b1;

    // Helpers are written for the widest supported code; callers zero-extend
    // their one-hot word and truncate the index to their own width.
    localparam int unsigned MAX_W = 8;
    localparam int unsigned MAX_N = 1 << MAX_W;

    // True when exactly one bit of v is set
    function automatic logic popcount_is_one(input logic [MAX_N-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        return seen && !multi;
    endfunction

    // Index of the set bit; only meaningful when popcount_is_one(v) holds
    function automatic logic [MAX_W-1:0] oh_index(input logic [MAX_N-1:0] v);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = idx | i[MAX_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/codec_fifo2.sv
// Two-entry synchronous FIFO with 1-bit wrapping pointers and no bypass.
module codec_fifo2 #(
    parameter int unsigned DW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    // Push while full and pop while empty are ignored
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    // Storage is reset, so the head is never X even when empty
    assign o_rdata = r_mem[r_rptr];

    // Pointer, occupancy and storage update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/onehot_codec.sv
// Registered bidirectional binary/one-hot converter with a 2-entry output
// buffer and a saturating count of invalid one-hot inputs.
module onehot_codec
    import onehot_codec_pkg::*;
#(
    parameter int unsigned W  = 3,
    parameter int unsigned CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [W-1:0]        bin_in,
    input  logic [(1<<W)-1:0]   oh_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<W)-1:0]   oh_out,
    output logic [W-1:0]        bin_out,
    output logic                err,
    output logic [CW-1:0]       err_cnt
);

    localparam int unsigned N  = 1 << W;
    localparam int unsigned DW = 1 + W + N;

    logic [MAX_N-1:0] w_oh_ext;
    logic [N-1:0]     w_oh;
    logic [W-1:0]     w_bin;
    logic             w_err;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [DW-1:0]    w_rdata;
    logic [CW-1:0]    r_err_cnt;

    // Zero-extend the one-hot input to the helper width
    always_comb begin
        w_oh_ext        = '0;
        w_oh_ext[N-1:0] = oh_in;
    end

    // Convert the input word; invalid one-hot echoes the input with index 0
    always_comb begin
        w_oh  = '0;
        w_bin = '0;
        w_err = 1'b0;
        if (mode == MODE_B2OH) begin
            w_oh  = {{(N-1){1'b0}}, 1'b1} << bin_in;
            w_bin = bin_in;
        end else begin
            w_oh = oh_in;
            if (popcount_is_one(w_oh_ext)) begin
                w_bin = W'(oh_index(w_oh_ext));
            end else begin
                w_err = 1'b1;
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    codec_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata ({w_err, w_bin, w_oh}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {err, bin_out, oh_out} = w_rdata;
    assign err_cnt                = r_err_cnt;

    // Count accepted invalid words, holding at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && (r_err_cnt != {CW{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_codec.sv
// Directed bench for onehot_codec: conversion, backpressure, FIFO order,
// reset flush and error-counter saturation.
module tb_onehot_codec;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [2:0] bin_in;
    logic [7:0] oh_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] oh_out;
    logic [2:0] bin_out;
    logic       err;
    logic [7:0] err_cnt;

    // Second instance with a 2-bit counter for saturation
    logic       s_in_valid;
    logic       s_in_ready;
    logic [7:0] s_oh_in;
    logic       s_out_valid;
    logic [7:0] s_oh_out;
    logic [2:0] s_bin_out;
    logic       s_err;
    logic [1:0] s_err_cnt;

    int total;
    int bad;

    onehot_codec #(.W(3), .CW(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .bin_in    (bin_in),
        .oh_in     (oh_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .oh_out    (oh_out),
        .bin_out   (bin_out),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    onehot_codec #(.W(3), .CW(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .mode      (1'b1),
        .bin_in    (3'd0),
        .oh_in     (s_oh_in),
        .out_valid (s_out_valid),
        .out_ready (1'b1),
        .oh_out    (s_oh_out),
        .bin_out   (s_bin_out),
        .err       (s_err),
        .err_cnt   (s_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        mode       = 1'b0;
        bin_in     = '0;
        oh_in      = '0;
        out_ready  = 1'b0;
        s_in_valid = 1'b0;
        s_oh_in    = '0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_oh_out", oh_out, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);

        // Mode 0 sweep at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_oh;
            exp_oh = 8'h01 << i;
            bin_in = 3'(i);
            step();
            check($sformatf("b2oh_valid_%0d", i), out_valid, 1);
            check($sformatf("b2oh_oh_%0d", i), oh_out, exp_oh);
            check($sformatf("b2oh_bin_%0d", i), bin_out, i);
            check($sformatf("b2oh_err_%0d", i), err, 0);
        end
        in_valid = 1'b0;
        step();
        check("b2oh_drain", out_valid, 0);

        // Mode 1: valid, zero, multi-bit
        in_valid = 1'b1;
        mode     = 1'b1;
        oh_in    = 8'h20;
        step();
        check("oh2b_20_bin", bin_out, 5);
        check("oh2b_20_err", err, 0);
        oh_in = 8'h00;
        step();
        check("oh2b_00_bin", bin_out, 0);
        check("oh2b_00_err", err, 1);
        check("oh2b_00_cnt", err_cnt, 1);
        oh_in = 8'h24;
        step();
        check("oh2b_24_bin", bin_out, 0);
        check("oh2b_24_err", err, 1);
        check("oh2b_24_oh", oh_out, 8'h24);
        check("oh2b_24_cnt", err_cnt, 2);
        in_valid = 1'b0;
        step();
        check("oh2b_drain", out_valid, 0);

        // Backpressure: 3, 6, 1 with out_ready low
        mode      = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin_in    = 3'd3;
        step();
        check("bp_ready1", in_ready, 1);
        check("bp_head1", oh_out, 8'h08);
        bin_in = 3'd6;
        step();
        check("bp_ready2", in_ready, 0);
        check("bp_head2", oh_out, 8'h08);
        bin_in = 3'd1;
        step();
        check("bp_ready3", in_ready, 0);
        check("bp_hold", oh_out, 8'h08);
        out_ready = 1'b1;
        step();
        check("bp_pop1", oh_out, 8'h40);
        check("bp_ready4", in_ready, 1);
        step();
        check("bp_pop2", oh_out, 8'h02);
        in_valid = 1'b0;
        step();
        check("bp_drain", out_valid, 0);
        check("bp_cnt_kept", err_cnt, 2);

        // Push+pop at count 1, then push attempt while full with pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin_in    = 3'd2;
        step();
        check("pp_head0", oh_out, 8'h04);
        out_ready = 1'b1;
        bin_in    = 3'd7;
        step();
        check("pp_head1", oh_out, 8'h80);
        check("pp_ready1", in_ready, 1);
        out_ready = 1'b0;
        bin_in    = 3'd4;
        step();
        check("pp_full", in_ready, 0);
        out_ready = 1'b1;
        bin_in    = 3'd5;
        step();
        check("pp_nopush_oh", oh_out, 8'h10);
        check("pp_nopush_bin", bin_out, 4);
        step();
        check("pp_late_push", oh_out, 8'h20);
        in_valid = 1'b0;
        step();
        check("pp_drain", out_valid, 0);

        // Reset with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin_in    = 3'd1;
        step();
        bin_in = 3'd2;
        step();
        check("mr_full", in_ready, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_err_cnt", err_cnt, 0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mr_no_stale_%0d", i), out_valid, 0);
        end

        // Saturation of the 2-bit counter
        s_in_valid = 1'b1;
        s_oh_in    = 8'h03;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_cnt;
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            step();
            check($sformatf("sat_cnt_%0d", i), s_err_cnt, exp_cnt);
        end
        s_in_valid = 1'b0;
        step();
        check("sat_hold", s_err_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_codec.md
Name: onehot_codec

Overview:
Parametrised, registered successor to the 3-bit binary-to-one-hot encoder. The block is bidirectional:
- Mode 0 converts binary to one-hot.
- Mode 1 converts one-hot to binary and validates the input (exactly one bit set).

Results pass through a 2-entry output buffer with valid/ready handshakes on both sides, so the block sits between pipeline stages that can stall.

Parameters:
- W, 3: binary code width.
- N, 2**W: one-hot width. Derived localparam; not overridable.
- CW, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- mode  in  1  0 = binary→one-hot, 1 = one-hot→binary; sampled with the input word.
- bin_in  in  W  binary input; used when mode=0.
- oh_in  in  N  one-hot input; used when mode=1.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts this cycle.
- oh_out  out  N  one-hot result of the head entry.
- bin_out  out  W  binary result of the head entry.
- err  out  1  head entry came from an invalid one-hot input.
- err_cnt  out  CW  saturating count of accepted invalid words.

Behaviour:
- Reset (async, immediate) clears:
  - buffer count to 0, both read/write pointers to 0;
  - out_valid=0, oh_out=0, bin_out=0, err=0, err_cnt=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Entries in flight are discarded; no output is produced for them.
- Handshakes:
  - Accept on the rising edge where in_valid && in_ready.
  - Pop on the rising edge where out_valid && out_ready.
  - in_ready = (count < 2); combinational from registered state only, with no dependence on out_ready.
  - While full, in_ready=0 even if a pop occurs in the same cycle. There is no bypass.
- Conversion is combinational on the input word; the result is written into the buffer at the accept edge.
  - Mode 0:
    - oh_out = 1 << bin_in; bin_out = bin_in; err=0.
    - Every binary value is legal, including the top code N-1 → MSB set.
  - Mode 1, popcount(oh_in)==1:
    - bin_out = index of the set bit; oh_out = oh_in; err=0.
  - Mode 1, popcount(oh_in)!=1 (zero bits or multiple bits):
    - bin_out = 0, oh_out = oh_in (echoed), err=1.
    - Not a priority encoder; the lowest set bit is NOT reported.
- Latency and throughput:
  - A word accepted at edge k is visible with out_valid=1 after edge k. One cycle latency from the empty state.
  - Full throughput of 1 word/cycle when out_ready is held high.
- Buffer rules:
  - Strict FIFO order.
  - Count update: push-only +1, pop-only −1, push+pop unchanged.
  - Push and pop in the same cycle are legal when count==1.
  - When empty, no push can be popped in the same cycle.
  - Pointers are 1 bit and wrap naturally.
- Output stability:
  - Head outputs are taken from registered storage.
  - They are stable while out_valid=1 and out_ready=0.
  - They are don't-care when out_valid=0, but are driven from the storage entry at the read pointer, never X after reset.
- err_cnt:
  - Increments by 1 at each accept edge carrying an invalid word.
  - Saturates at 2**CW−1.
  - Unaffected by pops.
  - Cleared only by rst.

Decomposition:
- Package onehot_codec_pkg:
  - Mode constants MODE_B2OH=1'b0 and MODE_OH2B=1'b1.
  - Function popcount_is_one(N-bit) → 1 bit.
  - Function oh_index(N-bit) → W bits.
- Sub-module codec_fifo2: parametrised-width 2-entry synchronous FIFO with push/pop/full/empty.
  - Stores the packed word {err, bin, oh}, width 1+W+N.
  - Instantiated once.
- The top level holds the combinational conversion and err_cnt.

Test Plan:
1. Reset mid-operation: rst pulsed with 2 entries buffered → out_valid=0, in_ready=1, err_cnt=0 immediately. No stale entries emerge afterwards.
2. Mode 0 sweep, W=3, bin_in=0..7, out_ready=1 → oh_out = 8'h01, 02, 04 … 80, one per cycle, err=0, 1-cycle latency.
3. Mode 1 with oh_in=8'h20 → bin_out=5, err=0. With oh_in=8'h00 → bin_out=0, err=1. With oh_in=8'h24 → bin_out=0, err=1, err_cnt=2.
4. Backpressure: out_ready=0, push 3 words (3, 6, 1) → in_ready=0 after the 2nd accept. Head holds oh_out=8'h08 stable. Releasing out_ready delivers 08, 40, 02 in order.
5. Simultaneous push+pop at count==1 → count stays 1, order preserved. Push attempt while full with pop → not accepted that cycle.
6. Saturation with CW=2: 5 invalid words accepted → err_cnt sequence 1, 2, 3, 3, 3.
